// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU front end.
// Holds the NOP/HLT encodings, the fetch FSM state type and the default reset PC.
// Imported by every stage that needs to decode or inject instructions.
package cpu_pkg;

  // Bubble injected into IF/ID on flush or after a halt has drained.
  localparam logic [15:0] NOP_INSTR        = 16'hB000;

  // Opcode field (bits 15:12) of the halt instruction.
  localparam logic [3:0]  HLT_OPCODE       = 4'hF;

  // PC loaded by reset unless the instance overrides it.
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  // Fetch FSM:
  //   ST_FETCH - address presented every cycle, IF/ID advances
  //   ST_HOLD  - downstream stalled, IM latch frozen, PC held
  //   ST_HALT  - HLT captured, fetch stopped until a redirect
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // True when the word carries the halt opcode.
  function automatic logic is_hlt(input logic [15:0] word);
    return (word[15:12] == HLT_OPCODE);
  endfunction

endpackage : cpu_pkg

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives IM address/read-enable, fills IF/ID.
// Latency: word at iaddr in cycle N appears in instr_IM_ID after the edge ending cycle N.
// Backpressure: stall_IM_ID freezes PC and IF/ID and drops rd_en; redirect overrides stall.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_IM_ID,
  input  logic        flow_change_ID_EX,
  input  logic [15:0] dst_ID_EX,
  input  logic [15:0] instr,
  output logic [15:0] iaddr,
  output logic        rd_en,
  output logic [15:0] instr_IM_ID,
  output logic [15:0] pc_IM_ID,
  output logic        valid_IM_ID,
  output logic        hlt_fetched
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_id_q, instr_id_d;
  logic [15:0]  pc_id_q, pc_id_d;
  logic         valid_id_q, valid_id_d;
  logic         hlt_q, hlt_d;

  // Incrementer wraps naturally from 16'hFFFF to 16'h0000.
  logic [15:0]  pc_inc;
  logic         word_is_hlt;

  assign pc_inc      = pc_q + 16'd1;
  assign word_is_hlt = is_hlt(instr);

  // IM is read whenever the fetched word will actually be consumed this cycle:
  // always in FETCH, and in HOLD only on the cycle the stall releases.
  // Keeping rd_en low otherwise leaves the IM output latch frozen on the held word.
  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      ST_FETCH: rd_en = 1'b1;
      ST_HOLD:  rd_en = ~stall_IM_ID;
      default:  rd_en = 1'b0;
    endcase
  end

  // Next-state and IF/ID update, priority redirect > stall > normal.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    valid_id_d = valid_id_q;
    hlt_d      = hlt_q;

    if (flow_change_ID_EX) begin
      // Squash whatever IM returns this cycle and restart at the target.
      state_d    = ST_FETCH;
      pc_d       = dst_ID_EX;
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
      hlt_d      = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH, ST_HOLD: begin
          if (stall_IM_ID) begin
            state_d = ST_HOLD;
          end else begin
            // A HOLD release is a plain fetch of the held PC, so nothing is
            // skipped or captured twice.
            instr_id_d = instr;
            pc_id_d    = pc_inc;
            valid_id_d = 1'b1;
            if (word_is_hlt) begin
              // PC stays on the HLT so iaddr stops advancing.
              state_d = ST_HALT;
              hlt_d   = 1'b1;
            end else begin
              state_d = ST_FETCH;
              pc_d    = pc_inc;
            end
          end
        end

        ST_HALT: begin
          // HLT word stays visible while decode is stalled, then drains to a bubble.
          if (!stall_IM_ID) begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
          end
        end

        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_id_q <= NOP_INSTR;
      pc_id_q    <= 16'h0000;
      valid_id_q <= 1'b0;
      hlt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_id_q <= instr_id_d;
      pc_id_q    <= pc_id_d;
      valid_id_q <= valid_id_d;
      hlt_q      <= hlt_d;
    end
  end

  assign iaddr       = pc_q;
  assign instr_IM_ID = instr_id_q;
  assign pc_IM_ID    = pc_id_q;
  assign valid_IM_ID = valid_id_q;
  assign hlt_fetched = hlt_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a behavioural IM and fetch model.
// Directed table, hand-written halt/async-reset sequences, then random traffic.
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit after it.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall_IM_ID;
  logic        flow_change_ID_EX;
  logic [15:0] dst_ID_EX;
  logic [15:0] instr;
  logic [15:0] iaddr;
  logic        rd_en;
  logic [15:0] instr_IM_ID;
  logic [15:0] pc_IM_ID;
  logic        valid_IM_ID;
  logic        hlt_fetched;

  int checks;
  int failures;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_IM_ID       (stall_IM_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dst_ID_EX         (dst_ID_EX),
    .instr             (instr),
    .iaddr             (iaddr),
    .rd_en             (rd_en),
    .instr_IM_ID       (instr_IM_ID),
    .pc_IM_ID          (pc_IM_ID),
    .valid_IM_ID       (valid_IM_ID),
    .hlt_fetched       (hlt_fetched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: latches during the low phase when enabled.
  logic [15:0] mem [0:65535];
  logic [15:0] im_q;
  always @(negedge clk) if (rd_en) im_q <= mem[iaddr];
  assign instr = im_q;

  function automatic logic [15:0] seq_word(input logic [15:0] a);
    logic [11:0] lo;
    lo = a[11:0] + 12'd1;
    return {4'h1, lo};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with rd_en sampled mid-cycle.
  task automatic tick(input logic s, input logic f, input logic [15:0] d, output logic rd_seen);
    stall_IM_ID       = s;
    flow_change_ID_EX = f;
    dst_ID_EX         = d;
    #1;
    rd_seen = rd_en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_iaddr"}, iaddr, 16'h0000);
    chk({tag, "_instr"}, instr_IM_ID, 16'hB000);
    chk({tag, "_pc"},    pc_IM_ID, 16'h0000);
    chk({tag, "_valid"}, {15'd0, valid_IM_ID}, 16'd0);
    chk({tag, "_hlt"},   {15'd0, hlt_fetched}, 16'd0);
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    stall_IM_ID       = 1'b0;
    flow_change_ID_EX = 1'b0;
    dst_ID_EX         = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        fc;
    logic [15:0] dst;
    logic        exp_rd;
    logic [15:0] exp_iaddr;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic s, input logic f, input logic [15:0] d, input logic rd,
                              input logic [15:0] ia, input logic [15:0] in, input logic [15:0] p,
                              input logic v);
    vec_t r;
    r.stall = s; r.fc = f; r.dst = d; r.exp_rd = rd;
    r.exp_iaddr = ia; r.exp_instr = in; r.exp_pc = p; r.exp_valid = v;
    return r;
  endfunction

  // Reference model state, expressed in spec terms rather than FSM encoding.
  logic [15:0] m_pc, m_instr, m_pc_id;
  logic        m_valid, m_hlt, m_halted, m_holding;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'hB000; m_pc_id = 16'h0000;
    m_valid = 1'b0; m_hlt = 1'b0; m_halted = 1'b0; m_holding = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic f, input logic [15:0] d);
    logic [15:0] w;
    if (f) begin
      m_pc = d; m_instr = 16'hB000; m_valid = 1'b0; m_hlt = 1'b0;
      m_halted = 1'b0; m_holding = 1'b0;
    end else if (m_halted) begin
      if (!s) begin m_instr = 16'hB000; m_valid = 1'b0; end
    end else if (s) begin
      m_holding = 1'b1;
    end else begin
      w = mem[m_pc];
      m_instr = w; m_pc_id = m_pc + 16'd1; m_valid = 1'b1; m_holding = 1'b0;
      if (w[15:12] == 4'hF) begin m_halted = 1'b1; m_hlt = 1'b1; end
      else m_pc = m_pc + 16'd1;
    end
  endtask

  initial begin
    logic rd;
    checks   = 0;
    failures = 0;
    for (int a = 0; a < 65536; a++) mem[a] = seq_word(16'(a));

    // ---------------- directed table ----------------
    vecs[0]  = mk(0, 0, 16'h0000, 1, 16'h0001, 16'h1001, 16'h0001, 1);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h0002, 16'h1002, 16'h0002, 1);
    vecs[2]  = mk(0, 0, 16'h0000, 1, 16'h0003, 16'h1003, 16'h0003, 1);
    vecs[3]  = mk(0, 0, 16'h0000, 1, 16'h0004, 16'h1004, 16'h0004, 1);
    vecs[4]  = mk(0, 0, 16'h0000, 1, 16'h0005, 16'h1005, 16'h0005, 1);
    vecs[5]  = mk(1, 0, 16'h0000, 1, 16'h0005, 16'h1005, 16'h0005, 1);
    vecs[6]  = mk(1, 0, 16'h0000, 0, 16'h0005, 16'h1005, 16'h0005, 1);
    vecs[7]  = mk(1, 0, 16'h0000, 0, 16'h0005, 16'h1005, 16'h0005, 1);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h0006, 16'h1006, 16'h0006, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 1, 16'h0007, 16'h1007, 16'h0007, 1);
    vecs[10] = mk(0, 0, 16'h0000, 1, 16'h0008, 16'h1008, 16'h0008, 1);
    vecs[11] = mk(0, 1, 16'h0040, 1, 16'h0040, 16'hB000, 16'h0008, 0);
    vecs[12] = mk(0, 0, 16'h0000, 1, 16'h0041, 16'h1041, 16'h0041, 1);
    vecs[13] = mk(1, 1, 16'h0100, 1, 16'h0100, 16'hB000, 16'h0041, 0);
    vecs[14] = mk(0, 0, 16'h0000, 1, 16'h0101, 16'h1101, 16'h0101, 1);
    vecs[15] = mk(0, 1, 16'hFFFF, 1, 16'hFFFF, 16'hB000, 16'h0101, 0);
    vecs[16] = mk(0, 0, 16'h0000, 1, 16'h0000, 16'h1000, 16'h0000, 1);
    vecs[17] = mk(0, 0, 16'h0000, 1, 16'h0001, 16'h1001, 16'h0001, 1);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].stall, vecs[i].fc, vecs[i].dst, rd);
      chk($sformatf("vec%0d_rd_en", i), {15'd0, rd}, {15'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_iaddr", i), iaddr, vecs[i].exp_iaddr);
      chk($sformatf("vec%0d_instr", i), instr_IM_ID, vecs[i].exp_instr);
      chk($sformatf("vec%0d_pc", i), pc_IM_ID, vecs[i].exp_pc);
      chk($sformatf("vec%0d_valid", i), {15'd0, valid_IM_ID}, {15'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_hlt", i), {15'd0, hlt_fetched}, 16'd0);
    end

    // ---------------- halt sequence ----------------
    mem[3] = 16'hF000;
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 0, 16'h0000, rd);
    chk("halt_pre_iaddr", iaddr, 16'h0003);
    tick(0, 0, 16'h0000, rd);                  // captures HLT
    chk("halt_cap_instr", instr_IM_ID, 16'hF000);
    chk("halt_cap_hlt", {15'd0, hlt_fetched}, 16'd1);
    chk("halt_cap_valid", {15'd0, valid_IM_ID}, 16'd1);
    chk("halt_cap_iaddr", iaddr, 16'h0003);
    tick(1, 0, 16'h0000, rd);                  // stalled in HALT: HLT held
    chk("halt_stall_rd_en", {15'd0, rd}, 16'd0);
    chk("halt_stall_instr", instr_IM_ID, 16'hF000);
    chk("halt_stall_valid", {15'd0, valid_IM_ID}, 16'd1);
    tick(0, 0, 16'h0000, rd);                  // HLT advances
    chk("halt_drain_rd_en", {15'd0, rd}, 16'd0);
    chk("halt_drain_instr", instr_IM_ID, 16'hB000);
    chk("halt_drain_valid", {15'd0, valid_IM_ID}, 16'd0);
    chk("halt_drain_hlt", {15'd0, hlt_fetched}, 16'd1);
    chk("halt_drain_iaddr", iaddr, 16'h0003);
    tick(0, 0, 16'h0000, rd);
    chk("halt_idle_rd_en", {15'd0, rd}, 16'd0);
    chk("halt_idle_iaddr", iaddr, 16'h0003);
    tick(0, 1, 16'h0010, rd);                  // redirect out of HALT
    chk("halt_redir_iaddr", iaddr, 16'h0010);
    chk("halt_redir_hlt", {15'd0, hlt_fetched}, 16'd0);
    chk("halt_redir_valid", {15'd0, valid_IM_ID}, 16'd0);
    tick(0, 0, 16'h0000, rd);
    chk("halt_resume_rd_en", {15'd0, rd}, 16'd1);
    chk("halt_resume_instr", instr_IM_ID, 16'h1011);
    chk("halt_resume_pc", pc_IM_ID, 16'h0011);
    chk("halt_resume_valid", {15'd0, valid_IM_ID}, 16'd1);
    mem[3] = seq_word(16'h0003);

    // ---------------- async reset mid-stream ----------------
    do_reset();
    for (int i = 0; i < 4; i++) tick(0, 0, 16'h0000, rd);
    chk("arst_pre_iaddr", iaddr, 16'h0004);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("arst_mid");
    #4 rst_n = 1'b1;                           // released after the low-phase latch
    @(posedge clk);
    #1;
    chk("arst_post_instr", instr_IM_ID, 16'h1001);
    chk("arst_post_pc", pc_IM_ID, 16'h0001);
    chk("arst_post_iaddr", iaddr, 16'h0001);
    chk("arst_post_valid", {15'd0, valid_IM_ID}, 16'd1);

    // ---------------- random traffic vs model ----------------
    for (int a = 0; a < 65536; a++) begin
      if ($urandom_range(0, 19) == 0) mem[a] = {4'hF, 12'($urandom)};
      else mem[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
    end
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        s, f, exp_rd;
      logic [15:0] d;
      s = ($urandom_range(0, 9) < 3);
      f = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       d = 16'hFFFF;
        1:       d = 16'($urandom_range(16'hFFF0, 16'hFFFF));
        default: d = 16'($urandom);
      endcase
      exp_rd = !m_halted && !(m_holding && s);
      tick(s, f, d, rd);
      model_edge(s, f, d);
      chk("rnd_rd_en", {15'd0, rd}, {15'd0, exp_rd});
      chk("rnd_iaddr", iaddr, m_pc);
      chk("rnd_instr", instr_IM_ID, m_instr);
      chk("rnd_pc", pc_IM_ID, m_pc_id);
      chk("rnd_valid", {15'd0, valid_IM_ID}, {15'd0, m_valid});
      chk("rnd_hlt", {15'd0, hlt_fetched}, {15'd0, m_hlt});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the 16-bit pipelined CPU. It sits directly upstream of the instruction memory `IM` and owns the program counter. It drives `IM` address and read-enable, captures the returned word into the IF/ID pipeline register, and handles stall, redirect (branch/jump flush) and halt.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk`  in  1: system clock; `IM` latches during the low phase.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall_IM_ID`  in  1: downstream stall; holds PC and IF/ID.
- `flow_change_ID_EX`  in  1: taken branch/jump; redirect plus flush.
- `dst_ID_EX`  in  16: redirect target address.
- `instr`  in  16: word returned by `IM`, valid by the rising edge.
- `iaddr`  out  16: `IM` address, equal to PC register (combinational from flop).
- `rd_en`  out  1: `IM` read enable.
- `instr_IM_ID`  out  16: IF/ID instruction register.
- `pc_IM_ID`  out  16: PC+1 of the captured instruction.
- `valid_IM_ID`  out  1: IF/ID holds a real instruction.
- `hlt_fetched`  out  1: HLT has been captured and fetch is halted.

## Operation
- FSM states are FETCH, HOLD and HALT. The reset state is FETCH.
- Per-edge priority, highest first: reset, then `flow_change_ID_EX`, then `stall_IM_ID`, then normal.
- **Redirect (any state):**
  - PC <= `dst_ID_EX`.
  - `instr_IM_ID` <= NOP_INSTR, `valid_IM_ID` <= 0, `hlt_fetched` <= 0.
  - Next state is FETCH. The word fetched this cycle is discarded.
- **FETCH, no stall:**
  - PC <= PC+1, wrapping 16'hFFFF to 16'h0000.
  - `instr_IM_ID` <= `instr`, `pc_IM_ID` <= PC+1, `valid_IM_ID` <= 1.
  - If `instr[15:12]` == HLT_OPCODE: next state is HALT, `hlt_fetched` <= 1, and PC is NOT incremented.
- **FETCH or HOLD with stall:** PC and all IF/ID outputs hold, next state is HOLD.
- **HOLD, stall released:** behaves exactly as FETCH in the same cycle, re-fetching the held PC. There are no lost or duplicated instructions.
- **HALT:**
  - PC holds.
  - IF/ID holds the HLT word while `stall_IM_ID`=1. Otherwise it becomes NOP_INSTR with `valid_IM_ID`=0 once the HLT has advanced.
  - HALT is left only by redirect (the HLT was on a wrong path) or by reset.
- `rd_en` = 1 in FETCH and HOLD-release cycles. It is 0 in HOLD while stalled and in HALT, so the `IM` output latch stays frozen.
- `stall_IM_ID` and `flow_change_ID_EX` both high: redirect wins.

## Timing
- Reset values: PC=`RESET_PC`, `iaddr`=`RESET_PC`, `instr_IM_ID`=NOP_INSTR, `pc_IM_ID`=0, `valid_IM_ID`=0, `hlt_fetched`=0. `rd_en`=1 from the first cycle after reset deasserts.
- Fetch latency is 1 cycle:
  - The address is presented in cycle N.
  - `IM` latches during the low half of cycle N.
  - `instr_IM_ID` is valid after the rising edge ending cycle N.
- Sustained throughput is 1 instruction per cycle with no stall.
- Redirect penalty: the fetch in the redirect cycle is squashed. The first target instruction is valid 2 edges after `flow_change_ID_EX` is sampled.
- Reset asserted mid-operation: all flops go to their reset values immediately (asynchronously). The state is FETCH on release.

## Structure
- Shared package `cpu_pkg`:
  - NOP_INSTR = 16'hB000.
  - HLT_OPCODE = 4'hF.
  - State enum for the fetch FSM.
  - Default RESET_PC.
- Single module, no sub-module. The PC incrementer and HLT decode are inline.
- Top-level wiring: `iaddr` connects to `IM.addr`, `rd_en` to `IM.rd_en`, and `IM.instr` to `instr`.

## Test plan
- **Reset then free-run:** `IM` holds 0x1001,0x1002,0x1003 at 0..2 -> `instr_IM_ID` follows 0x1001,0x1002,0x1003 on edges 1..3, `pc_IM_ID`=1,2,3, `valid_IM_ID`=1.
- **Stall:** stall for 3 cycles at PC=5 -> `iaddr` stuck at 5, `rd_en`=0 while stalled, IF/ID holds word @4. After release, word @5 is captured exactly once.
- **Redirect:** `flow_change_ID_EX`=1 with `dst_ID_EX`=0x0040 at PC=8 -> next IF/ID is NOP with valid=0, next `iaddr`=0x0040, and word @0x40 is captured on the following edge.
- **Halt:** word 0xF000 @3 -> `hlt_fetched`=1, `iaddr` stays 3, `rd_en`=0. IF/ID becomes NOP after one cycle. A later redirect to 0x10 clears halt and resumes fetch.
- **Simultaneous events:** stall and redirect high together -> redirect taken, state is FETCH. PC=16'hFFFF fetch -> next `iaddr`=0.
- **Async reset mid-stream:** `rst_n` low for half a cycle during fetch -> all outputs go to their reset values before the next edge, and fetch restarts at `RESET_PC`.
